// File: rtl/encoder_step_ctrl.sv
// Quadrature encoder front end: 2-flop sync, debounce, 4-phase Gray FSM, step pulses and position.
// Optional ENC_ACCEL_EN: same-direction steps within FAST_WIN cycles move position by 4.
module encoder_step_ctrl #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 8,
    parameter int FAST_WIN   = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             encInput_X,
    input  logic             encInput_Y,
    input  logic             clear,
    output logic             stepCW,
    output logic             stepCCW,
    output logic [CNT_W-1:0] position,
    output logic [1:0]       phase,
    output logic             err
);

    localparam int DEB_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int ACC_CNT = (DEB_CYCLES > 1) ? DEB_CYCLES - 2 : 0;

    typedef enum logic [2:0] {
        REST, CW1, CW2, CW3, CCW1, CCW2, CCW3, RESYNC
    } stateT;

    stateT            state;
    stateT            stateNext;
    logic [1:0]       s1;
    logic [1:0]       s2;
    logic [1:0]       prevS2;
    logic [DEB_W-1:0] debCnt;
    logic             stable;
    logic             differs;
    logic             accept;
    logic             jump;
    logic             cwEvent;
    logic             ccwEvent;
    logic             errEvent;
    logic [CNT_W-1:0] stepAmt;

    // A new value must be seen unchanged for DEB_CYCLES edges before it becomes the phase.
    assign stable  = (s2 == prevS2);
    assign differs = (s2 != phase);
    assign accept  = stable && differs && (debCnt == DEB_W'(ACC_CNT));
    assign jump    = ((s2 ^ phase) == 2'b11);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1     <= 2'b11;
            s2     <= 2'b11;
            prevS2 <= 2'b11;
            phase  <= 2'b11;
            debCnt <= '0;
        end else begin
            s1     <= {encInput_X, encInput_Y};
            s2     <= s1;
            prevS2 <= s2;
            if (!stable || !differs || accept) begin
                debCnt <= '0;
            end else begin
                debCnt <= debCnt + 1'b1;
            end
            if (accept) begin
                phase <= s2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= REST;
        end else begin
            state <= stateNext;
        end
    end

    // A two-bit jump landing directly on 11 is already back at rest.
    always_comb begin
        stateNext = state;
        if (accept) begin
            if (jump) begin
                stateNext = (s2 == 2'b11) ? REST : RESYNC;
            end else begin
                unique case (state)
                    REST: begin
                        if (s2 == 2'b01)      stateNext = CW1;
                        else if (s2 == 2'b10) stateNext = CCW1;
                    end
                    CW1: begin
                        if (s2 == 2'b00)      stateNext = CW2;
                        else if (s2 == 2'b11) stateNext = REST;
                    end
                    CW2: begin
                        if (s2 == 2'b10)      stateNext = CW3;
                        else if (s2 == 2'b01) stateNext = CW1;
                    end
                    CW3: begin
                        if (s2 == 2'b11)      stateNext = REST;
                        else if (s2 == 2'b00) stateNext = CW2;
                    end
                    CCW1: begin
                        if (s2 == 2'b00)      stateNext = CCW2;
                        else if (s2 == 2'b11) stateNext = REST;
                    end
                    CCW2: begin
                        if (s2 == 2'b01)      stateNext = CCW3;
                        else if (s2 == 2'b10) stateNext = CCW1;
                    end
                    CCW3: begin
                        if (s2 == 2'b11)      stateNext = REST;
                        else if (s2 == 2'b00) stateNext = CCW2;
                    end
                    RESYNC: begin
                        if (s2 == 2'b11)      stateNext = REST;
                    end
                    default: stateNext = REST;
                endcase
            end
        end
    end

    always_comb begin
        cwEvent  = 1'b0;
        ccwEvent = 1'b0;
        errEvent = 1'b0;
        if (accept) begin
            errEvent = jump;
            cwEvent  = !jump && (state == CW3)  && (s2 == 2'b11);
            ccwEvent = !jump && (state == CCW3) && (s2 == 2'b11);
        end
    end

`ifdef ENC_ACCEL_EN
    localparam int GAP_W = $clog2(FAST_WIN + 1);

    logic [GAP_W-1:0] gap;
    logic             lastCW;
    logic             fast;

    // gap starts saturated so the first step after reset is never fast.
    always_ff @(posedge clk) begin
        if (reset) begin
            gap    <= GAP_W'(FAST_WIN);
            lastCW <= 1'b0;
        end else if (cwEvent || ccwEvent) begin
            gap    <= '0;
            lastCW <= cwEvent;
        end else if (gap != GAP_W'(FAST_WIN)) begin
            gap    <= gap + 1'b1;
        end
    end

    assign fast    = (gap < GAP_W'(FAST_WIN)) && (lastCW == cwEvent);
    assign stepAmt = fast ? CNT_W'(4) : CNT_W'(1);
`else
    assign stepAmt = CNT_W'(1);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            stepCW   <= 1'b0;
            stepCCW  <= 1'b0;
            position <= '0;
            err      <= 1'b0;
        end else begin
            stepCW  <= cwEvent;
            stepCCW <= ccwEvent;
            if (clear) begin
                position <= '0;
            end else if (cwEvent) begin
                position <= position + stepAmt;
            end else if (ccwEvent) begin
                position <= position - stepAmt;
            end
            if (clear) begin
                err <= 1'b0;
            end else if (errEvent) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_encoder_step_ctrl.sv
// Bench for encoder_step_ctrl: random phase walks checked against a displacement-based detent model.
module tb_encoder_step_ctrl;

    localparam int DEB      = 4;
    localparam int FAST_WIN = 64;
    localparam int LAT      = DEB + 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       encX = 1'b1;
    logic       encY = 1'b1;
    logic       clear = 1'b0;
    logic       stepCW;
    logic       stepCCW;
    logic [7:0] position;
    logic [1:0] phase;
    logic       err;

    int checks = 0;
    int failures = 0;
    int cycleCnt = 0;

    logic [1:0] expQ[$];
    logic [1:0] obsQ[$];
    logic [1:0] phCode[4] = '{2'b11, 2'b01, 2'b00, 2'b10};

    logic [1:0] mPhase;
    int         mDisp;
    bit         mResync;
    logic       mErr;
    logic [7:0] mPos;
    bit         mHasLast;
    bit         mLastCw;
    int         mLastCycle;

    encoder_step_ctrl #(.DEB_CYCLES(DEB), .CNT_W(8), .FAST_WIN(FAST_WIN)) dut (
        .clk(clk), .reset(reset), .encInput_X(encX), .encInput_Y(encY), .clear(clear),
        .stepCW(stepCW), .stepCCW(stepCCW), .position(position), .phase(phase), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;
    always @(negedge clk) if (stepCW || stepCCW) obsQ.push_back({stepCCW, stepCW});

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int phIdx(logic [1:0] p);
        case (p)
            2'b11:   return 0;
            2'b01:   return 1;
            2'b00:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic void modelReset();
        mPhase = 2'b11; mDisp = 0; mResync = 0; mErr = 1'b0;
        mPos = 8'd0; mHasLast = 0; mLastCw = 0; mLastCycle = 0;
    endfunction

    // Phase index walks +1 per CW quarter-turn; a full detent back at 11 is a net +/-4.
    function automatic void modelApply(logic [1:0] p, int driveCycle);
        int diff;
        int amt;
        int sc;
        bit cw;
        if (p == mPhase) return;
        diff = (phIdx(p) - phIdx(mPhase) + 4) % 4;
        if (diff == 2) begin
            mErr = 1'b1;
            mResync = 1;
        end else if (!mResync) begin
            mDisp += (diff == 1) ? 1 : -1;
        end
        mPhase = p;
        if (p == 2'b11) begin
            if (!mResync && (mDisp == 4 || mDisp == -4)) begin
                cw = (mDisp == 4);
                sc = driveCycle + LAT;
                amt = 1;
`ifdef ENC_ACCEL_EN
                if (mHasLast && mLastCw == cw && (sc - mLastCycle) <= FAST_WIN) amt = 4;
`endif
                mHasLast = 1; mLastCw = cw; mLastCycle = sc;
                mPos = cw ? mPos + 8'(amt) : mPos - 8'(amt);
                expQ.push_back(cw ? 2'b01 : 2'b10);
            end
            mDisp = 0;
            mResync = 0;
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drivePhase(input logic [1:0] p, input int hold);
        {encX, encY} = p;
        modelApply(p, cycleCnt);
        tick(hold);
    endtask

    task automatic driveDetent(input bit cw, input int hold);
        for (int k = 1; k <= 4; k++) drivePhase(phCode[cw ? (k % 4) : ((4 - k) % 4)], hold);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        checks += 5;
        if (phase !== 2'b11) begin failures++; $display("FAIL reset_phase got %b exp 11", phase); end
        if (position !== 8'd0) begin failures++; $display("FAIL reset_position got %0d exp 0", position); end
        if (stepCW !== 1'b0) begin failures++; $display("FAIL reset_stepCW got %b exp 0", stepCW); end
        if (stepCCW !== 1'b0) begin failures++; $display("FAIL reset_stepCCW got %b exp 0", stepCCW); end
        if (err !== 1'b0) begin failures++; $display("FAIL reset_err got %b exp 0", err); end
        reset = 1'b0;
        modelReset();
        tick(10);
        obsQ.delete();
    endtask

    task automatic test_cw();
        drivePhase(2'b01, 1);
        tick(LAT - 2);
        checks++;
        if (phase !== 2'b11) begin failures++; $display("FAIL latency_early got %b exp 11", phase); end
        tick(1);
        checks++;
        if (phase !== 2'b01) begin failures++; $display("FAIL latency_exact got %b exp 01", phase); end
        tick(4);
        drivePhase(2'b00, 10);
        drivePhase(2'b10, 10);
        {encX, encY} = 2'b11;
        modelApply(2'b11, cycleCnt);
        tick(LAT - 1);
        checks++;
        if (stepCW !== 1'b0) begin failures++; $display("FAIL cw_pulse_early got %b exp 0", stepCW); end
        tick(1);
        checks += 3;
        if (stepCW !== 1'b1 || stepCCW !== 1'b0) begin
            failures++; $display("FAIL cw_pulse got cw=%b ccw=%b exp cw=1 ccw=0", stepCW, stepCCW);
        end
        if (position !== mPos) begin failures++; $display("FAIL cw_position got %0d exp %0d", position, mPos); end
        if (err !== 1'b0) begin failures++; $display("FAIL cw_err got %b exp 0", err); end
        tick(1);
        checks++;
        if (stepCW !== 1'b0) begin failures++; $display("FAIL cw_pulse_width got %b exp 0", stepCW); end
        tick(8);
        checks++;
        if (obsQ.size() != expQ.size()) begin
            failures++; $display("FAIL cw_events got %0d exp %0d", obsQ.size(), expQ.size());
        end else foreach (expQ[i]) begin
            checks++;
            if (obsQ[i] !== expQ[i]) begin failures++; $display("FAIL cw_event got %b exp %b", obsQ[i], expQ[i]); end
        end
        obsQ.delete(); expQ.delete();
    endtask

    task automatic test_ccw();
        clear = 1'b1; tick(1); clear = 1'b0; mPos = 8'd0;
        driveDetent(0, $urandom_range(6, 12));
        tick(10);
        checks += 3;
        if (position !== mPos) begin failures++; $display("FAIL ccw_position got %0h exp %0h", position, mPos); end
        if (position !== 8'hFF) begin failures++; $display("FAIL ccw_wrap got %0h exp ff", position); end
        if (err !== 1'b0) begin failures++; $display("FAIL ccw_err got %b exp 0", err); end
        checks++;
        if (obsQ.size() != expQ.size()) begin
            failures++; $display("FAIL ccw_events got %0d exp %0d", obsQ.size(), expQ.size());
        end else foreach (expQ[i]) begin
            checks++;
            if (obsQ[i] !== expQ[i]) begin failures++; $display("FAIL ccw_event got %b exp %b", obsQ[i], expQ[i]); end
        end
        obsQ.delete(); expQ.delete();
    endtask

    task automatic test_glitch();
        int bad = 0;
        for (int n = 0; n < 20; n++) begin
            encX = 1'b0;
            tick($urandom_range(1, DEB - 1));
            if (phase !== 2'b11) bad++;
            encX = 1'b1;
            tick($urandom_range(1, 4));
            if (phase !== 2'b11) bad++;
        end
        tick(10);
        checks += 3;
        if (bad != 0) begin failures++; $display("FAIL glitch_phase got %0d moves exp 0", bad); end
        if (obsQ.size() != 0) begin failures++; $display("FAIL glitch_events got %0d exp 0", obsQ.size()); end
        if (position !== mPos) begin failures++; $display("FAIL glitch_position got %0d exp %0d", position, mPos); end
        obsQ.delete();
    endtask

    task automatic test_reversal();
        drivePhase(2'b01, $urandom_range(6, 12));
        drivePhase(2'b00, $urandom_range(6, 12));
        drivePhase(2'b01, $urandom_range(6, 12));
        drivePhase(2'b11, $urandom_range(6, 12));
        tick(10);
        checks += 3;
        if (obsQ.size() != 0) begin failures++; $display("FAIL rev_events got %0d exp 0", obsQ.size()); end
        if (position !== mPos) begin failures++; $display("FAIL rev_position got %0d exp %0d", position, mPos); end
        if (err !== mErr) begin failures++; $display("FAIL rev_err got %b exp %b", err, mErr); end
        drivePhase(2'b00, 10);
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL jump_err got %b exp 1", err); end
        drivePhase(2'b10, 10);
        drivePhase(2'b11, 10);
        checks += 2;
        if (obsQ.size() != 0) begin failures++; $display("FAIL resync_events got %0d exp 0", obsQ.size()); end
        if (err !== mErr) begin failures++; $display("FAIL resync_err_sticky got %b exp %b", err, mErr); end
        driveDetent(1, 8);
        tick(10);
        checks += 2;
        if (position !== mPos) begin failures++; $display("FAIL after_resync_pos got %0d exp %0d", position, mPos); end
        if (obsQ.size() != expQ.size()) begin
            failures++; $display("FAIL after_resync_events got %0d exp %0d", obsQ.size(), expQ.size());
        end
        obsQ.delete(); expQ.delete();
        clear = 1'b1; tick(1); clear = 1'b0;
        mPos = 8'd0; mErr = 1'b0;
        checks += 2;
        if (err !== mErr) begin failures++; $display("FAIL clear_err got %b exp 0", err); end
        if (position !== mPos) begin failures++; $display("FAIL clear_position got %0d exp 0", position); end
    endtask

    task automatic test_reset_mid();
        drivePhase(2'b01, 8);
        drivePhase(2'b00, 8);
        drivePhase(2'b10, 8);
        {encX, encY} = 2'b11;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        modelReset();
        tick(12);
        checks += 3;
        if (obsQ.size() != 0) begin failures++; $display("FAIL midreset_events got %0d exp 0", obsQ.size()); end
        if (position !== 8'd0) begin failures++; $display("FAIL midreset_position got %0d exp 0", position); end
        if (phase !== 2'b11) begin failures++; $display("FAIL midreset_phase got %b exp 11", phase); end
        driveDetent(1, 7);
        tick(10);
        checks += 2;
        if (position !== mPos) begin failures++; $display("FAIL midreset_after_pos got %0d exp %0d", position, mPos); end
        if (obsQ.size() != expQ.size()) begin
            failures++; $display("FAIL midreset_after_events got %0d exp %0d", obsQ.size(), expQ.size());
        end
        obsQ.delete(); expQ.delete();
    endtask

    task automatic test_wrap();
        clear = 1'b1; tick(1); clear = 1'b0; mPos = 8'd0;
        for (int n = 0; n < 256; n++) driveDetent(1, 5);
        tick(10);
        checks += 2;
        if (position !== mPos) begin failures++; $display("FAIL wrap_position got %0d exp %0d", position, mPos); end
        if (obsQ.size() != expQ.size()) begin
            failures++; $display("FAIL wrap_events got %0d exp %0d", obsQ.size(), expQ.size());
        end
        obsQ.delete(); expQ.delete();
        drivePhase(2'b01, 8);
        drivePhase(2'b00, 8);
        drivePhase(2'b10, 8);
        {encX, encY} = 2'b11;
        modelApply(2'b11, cycleCnt);
        tick(LAT - 1);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        mPos = 8'd0;
        checks += 2;
        if (stepCW !== 1'b1) begin failures++; $display("FAIL clear_step_pulse got %b exp 1", stepCW); end
        if (position !== mPos) begin failures++; $display("FAIL clear_step_position got %0d exp 0", position); end
        tick(8);
        obsQ.delete(); expQ.delete();
    endtask

    task automatic test_accel();
        logic [7:0] want;
        reset = 1'b1; tick(2); reset = 1'b0; modelReset(); tick(4);
        driveDetent(1, 5);
        driveDetent(1, 5);
        tick(10);
`ifdef ENC_ACCEL_EN
        want = 8'd5;
`else
        want = 8'd2;
`endif
        checks += 2;
        if (position !== mPos) begin failures++; $display("FAIL accel_model got %0d exp %0d", position, mPos); end
        if (position !== want) begin failures++; $display("FAIL accel_position got %0d exp %0d", position, want); end
        obsQ.delete(); expQ.delete();
    endtask

    task automatic test_random_walk();
        int idx;
        int r;
        for (int n = 0; n < 120; n++) begin
            idx = phIdx(mPhase);
            r = $urandom_range(0, 19);
            if (r == 0)      idx = (idx + 2) % 4;
            else if (r < 12) idx = (idx + 1) % 4;
            else             idx = (idx + 3) % 4;
            drivePhase(phCode[idx], $urandom_range(5, 10));
        end
        tick(12);
        checks += 3;
        if (phase !== mPhase) begin failures++; $display("FAIL rand_phase got %b exp %b", phase, mPhase); end
        if (position !== mPos) begin failures++; $display("FAIL rand_position got %0d exp %0d", position, mPos); end
        if (err !== mErr) begin failures++; $display("FAIL rand_err got %b exp %b", err, mErr); end
        checks++;
        if (obsQ.size() != expQ.size()) begin
            failures++; $display("FAIL rand_events got %0d exp %0d", obsQ.size(), expQ.size());
        end else foreach (expQ[i]) begin
            checks++;
            if (obsQ[i] !== expQ[i]) begin failures++; $display("FAIL rand_event got %b exp %b", obsQ[i], expQ[i]); end
        end
        obsQ.delete(); expQ.delete();
    endtask

    initial begin
        modelReset();
        test_reset();
        test_cw();
        test_ccw();
        test_glitch();
        test_reversal();
        test_reset_mid();
        test_wrap();
        test_accel();
        test_random_walk();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
